alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the combinational ALU. Accepts one operation per valid/ready handshake, executes logic, add, sub and compare in one cycle, and runs multiply and divide iteratively over WIDTH cycles. Results and per-operation (non-sticky) status flags are held in an output register until the consumer accepts them. Sits between the decode/operand stage and writeback in the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_mc_muldiv.sv | 124 ++++++++++++
 rtl/alu_mc.sv | 186 ++++++++++++++++++
 tb/tb_alu_mc.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode, status-bit and FSM-state definitions for the
//               multi-cycle ALU and its iterative multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcodes carried in alu_control[3:0]
    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_MUL = 4'b0011;
    localparam logic [3:0] c_OP_DIV = 4'b0100;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;

    // alu_control bit selecting unsigned MUL/DIV/SLT
    localparam int c_CTRL_UNSIGNED = 4;

    // Bit positions inside alu_status
    localparam int c_STAT_ZERO    = 7;
    localparam int c_STAT_OVF     = 6;
    localparam int c_STAT_CARRY   = 5;
    localparam int c_STAT_NEG     = 4;
    localparam int c_STAT_ILLEGAL = 3;
    localparam int c_STAT_DIVZ    = 2;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mc_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc_muldiv
// Description : Iterative engine: shift-add multiply or restoring divide, one
//               bit per cycle over WIDTH cycles. Signed operands are reduced to
//               magnitudes on start and the sign is re-applied on the final
//               cycle. done/result/overflow are valid in the last iteration
//               cycle so the caller can register them on that same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int             CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic                 r_busy;
    logic                 r_div;
    logic                 r_signed;
    logic                 r_neg;
    logic                 r_div_ovf;
    logic [CNT_W-1:0]     r_count;
    // Multiply: {partial product high, multiplier/product low}.
    // Divide:   {remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0]   r_work;
    // Multiplicand or divisor magnitude
    logic [WIDTH-1:0]     r_operand;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;

    assign w_a_neg = is_signed & operand_a[WIDTH-1];
    assign w_b_neg = is_signed & operand_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~operand_a + 1'b1) : operand_a;
    assign w_b_mag = w_b_neg ? (~operand_b + 1'b1) : operand_b;

    assign w_mul_sum   = {1'b0, r_work[2*WIDTH-1:WIDTH]}
                       + (r_work[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_operand};

    // One multiply or divide step applied to the working register
    always_comb begin
        w_next = r_work;
        if (r_div) begin
            if (!w_div_diff[WIDTH])
                w_next = {w_div_diff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};
            else
                w_next = {w_div_shift[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};
        end else begin
            w_next = {w_mul_sum, r_work[WIDTH-1:1]};
        end
    end

    // Final sign correction and overflow, using the last step's outcome
    always_comb begin
        w_prod   = r_neg ? (~w_next + 1'b1) : w_next;
        w_quot   = r_neg ? (~w_next[WIDTH-1:0] + 1'b1) : w_next[WIDTH-1:0];
        result   = r_div ? w_quot : w_prod[WIDTH-1:0];
        done     = r_busy && (r_count == c_LAST);
        if (r_div)
            overflow = r_div_ovf;
        else if (r_signed)
            overflow = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
        else
            overflow = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    end

    // Load operands on start, then iterate until the last bit is processed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_div     <= 1'b0;
            r_signed  <= 1'b0;
            r_neg     <= 1'b0;
            r_div_ovf <= 1'b0;
            r_count   <= '0;
            r_work    <= '0;
            r_operand <= '0;
        end else if (start) begin
            r_busy    <= 1'b1;
            r_div     <= op_div;
            r_signed  <= is_signed;
            r_neg     <= w_a_neg ^ w_b_neg;
            // Only the signed MIN / -1 quotient cannot be represented
            r_div_ovf <= is_signed
                         && (operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                         && (operand_b == {WIDTH{1'b1}});
            r_count   <= '0;
            r_work    <= {{WIDTH{1'b0}}, w_a_mag};
            r_operand <= w_b_mag;
        end else if (r_busy) begin
            r_work <= w_next;
            if (r_count == c_LAST)
                r_busy <= 1'b0;
            else
                r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with valid/ready handshakes on both sides.
//               Logic/add/sub/compare complete on the accept edge; multiply and
//               divide run in alu_mc_muldiv. Result and status are held in an
//               output register until the consumer accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_operand_1,
    input  logic [WIDTH-1:0] alu_operand_2,
    input  logic [5:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [7:0]       alu_status
);

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_result;
    logic [7:0]        r_status;

    logic [3:0]        w_op;
    logic              w_unsigned;
    logic              w_unused_ctrl;
    logic              w_accept;
    logic              w_b_zero;
    logic              w_is_long;
    logic              w_start;
    logic              w_load_sc;
    logic              w_load_eng;

    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH:0]    w_sum;
    logic              w_add_ovf;
    logic              w_slt;
    logic [WIDTH-1:0]  w_sc_result;
    logic              w_sc_ovf;
    logic              w_sc_carry;
    logic              w_sc_ill;
    logic              w_sc_dz;
    logic [7:0]        w_sc_status;

    logic              w_eng_done;
    logic [WIDTH-1:0]  w_eng_result;
    logic              w_eng_ovf;
    logic [7:0]        w_eng_status;

    assign w_op          = alu_control[3:0];
    assign w_unsigned    = alu_control[c_CTRL_UNSIGNED];
    assign w_unused_ctrl = alu_control[5];
    assign w_accept      = in_valid && (r_state == ST_IDLE);
    assign w_b_zero      = (alu_operand_2 == {WIDTH{1'b0}});
    // Divide by zero short-circuits to a one-cycle result
    assign w_is_long     = (w_op == c_OP_MUL) || ((w_op == c_OP_DIV) && !w_b_zero);

    // Shared adder: SUB is A + ~B + 1 so carry-out means "no borrow"
    assign w_b_eff   = (w_op == c_OP_SUB) ? ~alu_operand_2 : alu_operand_2;
    assign w_sum     = {1'b0, alu_operand_1} + {1'b0, w_b_eff}
                     + {{WIDTH{1'b0}}, (w_op == c_OP_SUB)};
    assign w_add_ovf = (alu_operand_1[WIDTH-1] == w_b_eff[WIDTH-1])
                    && (w_sum[WIDTH-1] != alu_operand_1[WIDTH-1]);
    assign w_slt     = w_unsigned ? (alu_operand_1 < alu_operand_2)
                                  : ($signed(alu_operand_1) < $signed(alu_operand_2));

    // Single-cycle result and raw flags, computed straight from the inputs
    always_comb begin
        w_sc_result = '0;
        w_sc_ovf    = 1'b0;
        w_sc_carry  = 1'b0;
        w_sc_ill    = 1'b0;
        w_sc_dz     = 1'b0;
        case (w_op)
            c_OP_AND: w_sc_result = alu_operand_1 & alu_operand_2;
            c_OP_OR:  w_sc_result = alu_operand_1 | alu_operand_2;
            c_OP_ADD, c_OP_SUB: begin
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_ovf    = w_add_ovf;
                w_sc_carry  = w_sum[WIDTH];
            end
            c_OP_SLT: w_sc_result = {{(WIDTH-1){1'b0}}, w_slt};
            c_OP_DIV: begin
                w_sc_result = {WIDTH{1'b1}};
                w_sc_dz     = 1'b1;
            end
            c_OP_MUL: w_sc_result = '0;
            default:  w_sc_ill    = 1'b1;
        endcase
    end

    // Pack status words; zero/negative always follow the final result
    always_comb begin
        w_sc_status                 = '0;
        w_sc_status[c_STAT_ZERO]    = (w_sc_result == {WIDTH{1'b0}});
        w_sc_status[c_STAT_OVF]     = w_sc_ovf;
        w_sc_status[c_STAT_CARRY]   = w_sc_carry;
        w_sc_status[c_STAT_NEG]     = w_sc_result[WIDTH-1];
        w_sc_status[c_STAT_ILLEGAL] = w_sc_ill;
        w_sc_status[c_STAT_DIVZ]    = w_sc_dz;
        w_eng_status                = '0;
        w_eng_status[c_STAT_ZERO]   = (w_eng_result == {WIDTH{1'b0}});
        w_eng_status[c_STAT_OVF]    = w_eng_ovf;
        w_eng_status[c_STAT_NEG]    = w_eng_result[WIDTH-1];
    end

    alu_mc_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start     (w_start),
        .op_div    (w_op == c_OP_DIV),
        .is_signed (!w_unsigned),
        .operand_a (alu_operand_1),
        .operand_b (alu_operand_2),
        .done      (w_eng_done),
        .result    (w_eng_result),
        .overflow  (w_eng_ovf)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_op == c_OP_MUL)
                        w_state_next = ST_MUL;
                    else if ((w_op == c_OP_DIV) && !w_b_zero)
                        w_state_next = ST_DIV;
                    else
                        w_state_next = ST_DONE;
                end
            end
            ST_MUL, ST_DIV: if (w_eng_done) w_state_next = ST_DONE;
            ST_DONE:        if (out_ready)  w_state_next = ST_IDLE;
            default:        w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes, engine start and output-register load enables
    always_comb begin
        in_ready   = (r_state == ST_IDLE);
        out_valid  = (r_state == ST_DONE);
        w_start    = w_accept && w_is_long;
        w_load_sc  = w_accept && !w_is_long;
        w_load_eng = ((r_state == ST_MUL) || (r_state == ST_DIV)) && w_eng_done;
    end

    // Output registers, held until the next operation completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_status <= '0;
        end else if (w_load_sc) begin
            r_result <= w_sc_result;
            r_status <= w_sc_status;
        end else if (w_load_eng) begin
            r_result <= w_eng_result;
            r_status <= w_eng_status;
        end
    end

    assign alu_result = r_result;
    assign alu_status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Self-checking bench for alu_mc: directed scenarios plus random
//               operations compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic [5:0]        ctrl = '0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  alu_result;
    logic [7:0]        alu_status;

    int n_cmp = 0;
    int n_bad = 0;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_operand_1 (a),
        .alu_operand_2 (b),
        .alu_control   (ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_result    (alu_result),
        .alu_status    (alu_status)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the operation's meaning
    function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                  input logic [5:0] ic, output logic [31:0] r,
                                  output logic [7:0] s, output int lat);
        longint     sa, sb, q;
        logic [63:0] p;
        logic [32:0] t;
        logic       ovf, cy, ill, dz;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        ovf = 1'b0; cy = 1'b0; ill = 1'b0; dz = 1'b0; lat = 1; r = '0;
        case (ic[3:0])
            4'b0000: r = ia & ib;
            4'b0001: r = ia | ib;
            4'b0010: begin
                t = {1'b0, ia} + {1'b0, ib};
                r = t[31:0]; cy = t[32];
                q = sa + sb;
                ovf = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            end
            4'b0110: begin
                t = {1'b0, ia} + {1'b0, ~ib} + 33'd1;
                r = t[31:0]; cy = t[32];
                q = sa - sb;
                ovf = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            end
            4'b0011: begin
                lat = WIDTH + 1;
                if (ic[4]) begin
                    p = {32'd0, ia} * {32'd0, ib};
                    ovf = (p[63:32] != 32'd0);
                end else begin
                    q = sa * sb;
                    p = q;
                    ovf = (q > 64'sd2147483647) || (q < -64'sd2147483648);
                end
                r = p[31:0];
            end
            4'b0100: begin
                if (ib == 32'd0) begin
                    r = 32'hFFFF_FFFF; dz = 1'b1;
                end else begin
                    lat = WIDTH + 1;
                    if (ic[4]) begin
                        r = ia / ib;
                    end else begin
                        q = sa / sb;
                        p = q;
                        r = p[31:0];
                        ovf = (q > 64'sd2147483647);
                    end
                end
            end
            4'b0111: r = (ic[4] ? (ia < ib) : (sa < sb)) ? 32'd1 : 32'd0;
            default: begin r = '0; ill = 1'b1; end
        endcase
        s = {(r == 32'd0), ovf, cy, r[31], ill, dz, 2'b00};
    endfunction

    // Present one operation (called #1 after a rising edge) and wait for out_valid
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [5:0] ic,
                         output logic [31:0] r, output logic [7:0] s, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
            n_bad++; n_cmp++;
        end
        a = ia; b = ib; ctrl = ic; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
            n_bad++; n_cmp++;
        end
        r = alu_result;
        s = alu_status;
    endtask

    task automatic ack_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        if ({out_valid, alu_result, alu_status} !== 41'd0) begin
            $display("FAIL reset_outputs: got v=%b r=%h s=%h required 0/0/0", out_valid, alu_result, alu_status);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_add_sub_logic();
        logic [31:0] r; logic [7:0] s; int lat;
        do_op(32'h7FFF_FFFF, 32'd1, 6'b000010, r, s, lat);
        if ({r, s} !== {32'h8000_0000, 8'h50} || lat !== 1) begin
            $display("FAIL add_ovf: got r=%h s=%h lat=%0d required r=80000000 s=50 lat=1", r, s, lat);
            n_bad++;
        end
        n_cmp++;
        ack_result();
        do_op(32'd5, 32'd5, 6'b000110, r, s, lat);
        if ({r, s} !== {32'd0, 8'hA0}) begin
            $display("FAIL sub_zero: got r=%h s=%h required r=0 s=a0", r, s);
            n_bad++;
        end
        n_cmp++;
        ack_result();
        do_op(32'hF0, 32'h0F, 6'b000000, r, s, lat);
        if ({r, s} !== {32'd0, 8'h80}) begin
            $display("FAIL and_nonsticky: got r=%h s=%h required r=0 s=80", r, s);
            n_bad++;
        end
        n_cmp++;
        ack_result();
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [7:0] s; int lat;
        do_op(32'hFFFF_FFFD, 32'd7, 6'b000011, r, s, lat);
        if ({r, s} !== {32'hFFFF_FFEB, 8'h10} || lat !== WIDTH + 1) begin
            $display("FAIL mul_signed: got r=%h s=%h lat=%0d required r=ffffffeb s=10 lat=33", r, s, lat);
            n_bad++;
        end
        n_cmp++;
        ack_result();
        do_op(32'h0001_0000, 32'h0001_0000, 6'b010011, r, s, lat);
        if ({r, s} !== {32'd0, 8'hC0}) begin
            $display("FAIL mul_unsigned_ovf: got r=%h s=%h required r=0 s=c0", r, s);
            n_bad++;
        end
        n_cmp++;
        ack_result();
    endtask

    task automatic test_div();
        logic [31:0] r; logic [7:0] s; int lat;
        do_op(32'hFFFF_FFF9, 32'd2, 6'b000100, r, s, lat);
        if ({r, s} !== {32'hFFFF_FFFD, 8'h10} || lat !== WIDTH + 1) begin
            $display("FAIL div_signed: got r=%h s=%h lat=%0d required r=fffffffd s=10 lat=33", r, s, lat);
            n_bad++;
        end
        n_cmp++;
        ack_result();
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 6'b000100, r, s, lat);
        if ({r, s} !== {32'h8000_0000, 8'h50}) begin
            $display("FAIL div_min_neg1: got r=%h s=%h required r=80000000 s=50", r, s);
            n_bad++;
        end
        n_cmp++;
        ack_result();
        do_op(32'd9, 32'd0, 6'b000100, r, s, lat);
        if ({r, s} !== {32'hFFFF_FFFF, 8'h14} || lat !== 1) begin
            $display("FAIL div_by_zero: got r=%h s=%h lat=%0d required r=ffffffff s=14 lat=1", r, s, lat);
            n_bad++;
        end
        n_cmp++;
        ack_result();
    endtask

    task automatic test_hold_illegal();
        logic [31:0] r; logic [7:0] s; int lat;
        do_op(32'h0000_00A5, 32'h0000_5A00, 6'b000001, r, s, lat);
        for (int i = 0; i < 10; i++) begin
            a = 32'd9; b = 32'd0; ctrl = 6'b000100;
            in_valid = i[0];
            @(posedge clk); #1;
            if ({out_valid, in_ready, alu_result, alu_status} !== {1'b1, 1'b0, 32'h5AA5, 8'h00}) begin
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b r=%h s=%h required v=1 rdy=0 r=5aa5 s=00",
                         i, out_valid, in_ready, alu_result, alu_status);
                n_bad++;
            end
            n_cmp++;
        end
        in_valid = 1'b0;
        ack_result();
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL hold_ignored: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
            n_bad++;
        end
        n_cmp++;
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 6'b101111, r, s, lat);
        if ({r, s} !== {32'd0, 8'h88} || lat !== 1) begin
            $display("FAIL illegal_op: got r=%h s=%h lat=%0d required r=0 s=88 lat=1", r, s, lat);
            n_bad++;
        end
        n_cmp++;
        ack_result();
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r; logic [7:0] s; int lat;
        do_op(32'h12, 32'h30, 6'b000001, r, s, lat);
        ack_result();
        a = 32'd3; b = 32'd5; ctrl = 6'b000011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL mul_busy: got rdy=%b v=%b required rdy=0 v=0", in_ready, out_valid);
            n_bad++;
        end
        n_cmp++;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        if ({out_valid, alu_result, alu_status} !== 41'd0) begin
            $display("FAIL midflight_reset: got v=%b r=%h s=%h required 0/0/0", out_valid, alu_result, alu_status);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL post_reset_idle: got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
            n_bad++;
        end
        n_cmp++;
        do_op(32'd100, 32'd23, 6'b000010, r, s, lat);
        if ({r, s} !== {32'd123, 8'h00} || lat !== 1) begin
            $display("FAIL post_reset_add: got r=%h s=%h lat=%0d required r=7b s=00 lat=1", r, s, lat);
            n_bad++;
        end
        n_cmp++;
        ack_result();
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
        if ($urandom_range(0, 3) == 0)
            return specials[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    task automatic test_random();
        logic [3:0]  ops [8];
        logic [31:0] ra, rb, r, er;
        logic [7:0]  s, es;
        logic [5:0]  c;
        int          lat, elat;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0100, 4'b0111, 4'b1010};
        for (int i = 0; i < 40; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            c  = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ops[$urandom_range(0, 7)]};
            if (c[3:0] == 4'b1010)
                c[3:0] = 4'($urandom_range(8, 15));
            model(ra, rb, c, er, es, elat);
            do_op(ra, rb, c, r, s, lat);
            if ({r, s} !== {er, es} || lat !== elat) begin
                $display("FAIL random%0d a=%h b=%h ctrl=%b: got r=%h s=%h lat=%0d required r=%h s=%h lat=%0d",
                         i, ra, rb, c, r, s, lat, er, es, elat);
                n_bad++;
            end
            n_cmp++;
            ack_result();
        end
    endtask

    initial begin
        test_reset();
        test_add_sub_logic();
        test_mul();
        test_div();
        test_hold_illegal();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
